multiword_adder_seq: RTL and testbench
======================================

MULTIWORD_ADDER_SEQ -- requirements
Module: multiword_adder_seq

Interface
REQ-001 Parameter: SLICES, default 4, number of 16-bit slices; operand width W = 16*SLICES; legal range 2..8.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 a  input  W  first operand; captured on the accepted start.
REQ-006 b  input  W  second operand; captured on the accepted start.
REQ-007 cin  input  1  carry-in to slice 0; captured on the accepted start.
REQ-008 busy  output  1  high while slices are being added (RUN).
REQ-009 done  output  1  one-cycle completion pulse (DONE).
REQ-010 sum  output  W  registered result; held until the next accepted start.
REQ-011 cout  output  1  registered carry-out of the top slice; held like sum.

Function
REQ-012 The block SHALL instantiate the team's existing 16-bit CLA adder (A, B, cin -> S, P[3:0], G[3:0]) once and time-share it across slices.
REQ-013 Slice carry-out SHALL be G[3] | P[3]G[2] | P[3]P[2]G[1] | P[3]P[2]P[1]G[0] | P[3]P[2]P[1]P[0]cin, computed from that instance's outputs.
REQ-014 FSM states SHALL be IDLE, RUN, DONE; encoding is implementation choice.
REQ-015 IDLE: on edge with start=1, latch a, b, cin into internal registers, set slice index to 0 and go to RUN; sum and cout are not modified.
REQ-016 RUN: each edge writes the CLA S into sum[16*idx+15:16*idx], stores slice carry-out into the carry register and increments idx.
REQ-017 RUN -> DONE on the edge that processes idx = SLICES-1; that edge also loads cout with the final slice carry-out.
REQ-018 DONE: done=1, busy=0 for exactly one cycle; next edge returns to IDLE unconditionally.
REQ-019 Latency: done SHALL be high in the cycle following the SLICES-th edge after the accepting edge (4 RUN cycles for SLICES=4).
REQ-020 start SHALL be ignored in RUN and DONE; no queuing; operand changes after acceptance SHALL not affect the result.
REQ-021 Slice index SHALL be ceil(log2(SLICES)) bits wide and never exceed SLICES-1.
REQ-022 Addition SHALL be unsigned modulo 2^W with the carry out of bit W-1 reported on cout.

Reset
REQ-023 rst_n low SHALL immediately force state IDLE, busy=0, done=0, sum=0, cout=0, index=0 and clear the internal operand and carry registers.
REQ-024 Reset asserted mid-RUN SHALL abandon the operation; no done pulse follows its release.
REQ-025 The first start SHALL be accepted on the first rising edge after rst_n is released.

Configuration
REQ-026 Macro SUBTRACT_EN: when defined, an extra input port sub (1 bit, sampled with start) SHALL exist; sub=1 computes a + ~b + 1 (cin ignored) and cout then means "no borrow".
REQ-027 Without SUBTRACT_EN, the sub port SHALL be absent and the block SHALL only add a + b + cin.

Verification (SLICES=4)
REQ-028 a=0x19E, b=0x40C, cin=0, start -> done after 4 RUN cycles, sum=0x0000_0000_0000_05AA, cout=0.
REQ-029 a=0x0000_0000_0000_FFFF, b=0x1, cin=0 -> sum=0x0000_0000_0001_0000, cout=0 (inter-slice carry).
REQ-030 a=0xFFFF_FFFF_FFFF_FFFF, b=0, cin=1 -> sum=0, cout=1 (full ripple across all slices); a=b=0x8000_0000_0000_0000, cin=0 -> sum=0, cout=1.
REQ-031 Pulse start again in RUN with different a/b -> ignored; result matches first operation; busy high exactly 4 cycles, done high exactly 1 cycle.
REQ-032 Assert rst_n=0 in 2nd RUN cycle -> busy, done, sum, cout all 0 immediately; no done pulse after release; next start completes normally.
REQ-033 With SUBTRACT_EN: a=5, b=7, sub=1 -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0; a=7, b=5, sub=1 -> sum=2, cout=1.

Source files
------------

// File: rtl/multiword_adder_seq.sv
// Sequential W=16*SLICES adder time-sharing one 16-bit CLA; done SLICES+1 cycles after accepted start, start ignored while busy.
// Optional SUBTRACT_EN macro adds a sub input: a + ~b + 1, cout then means "no borrow".

module cla16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] s,
  output logic [3:0]  p,
  output logic [3:0]  g
);
  logic [15:0] pb;
  logic [15:0] gb;
  logic [3:0]  gc;
  logic        cc;

  always_comb begin
    pb = a ^ b;
    gb = a & b;
    p  = '0;
    g  = '0;
    gc = '0;
    s  = '0;
    cc = 1'b0;
    for (int k = 0; k < 4; k++) begin
      p[k] = &pb[4*k +: 4];
      g[k] = gb[4*k+3] | (pb[4*k+3] & gb[4*k+2]) |
             (pb[4*k+3] & pb[4*k+2] & gb[4*k+1]) |
             (pb[4*k+3] & pb[4*k+2] & pb[4*k+1] & gb[4*k]);
    end
    // Group carries come from group P/G; bits ripple only inside a nibble.
    gc[0] = cin;
    for (int k = 1; k < 4; k++) begin
      gc[k] = g[k-1] | (p[k-1] & gc[k-1]);
    end
    for (int k = 0; k < 4; k++) begin
      cc = gc[k];
      for (int j = 0; j < 4; j++) begin
        s[4*k+j] = pb[4*k+j] ^ cc;
        cc       = gb[4*k+j] | (pb[4*k+j] & cc);
      end
    end
  end
endmodule

module multiword_adder_seq #(
  parameter int SLICES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [16*SLICES-1:0] a,
  input  logic [16*SLICES-1:0] b,
  input  logic                 cin,
`ifdef SUBTRACT_EN
  input  logic                 sub,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [16*SLICES-1:0] sum,
  output logic                 cout
);
  localparam int W  = 16 * SLICES;
  localparam int IW = $clog2(SLICES);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic            carry_q;
  logic [IW-1:0]   idx;
  logic [W-1:0]    b_in;
  logic            cin_in;
  logic [15:0]     a_sl;
  logic [15:0]     b_sl;
  logic [15:0]     s;
  logic [3:0]      p;
  logic [3:0]      g;
  logic            slice_co;
  logic            last;

`ifdef SUBTRACT_EN
  assign b_in   = sub ? ~b : b;
  assign cin_in = sub | cin;
`else
  assign b_in   = b;
  assign cin_in = cin;
`endif

  assign a_sl = a_q[16*idx +: 16];
  assign b_sl = b_q[16*idx +: 16];
  assign last = (idx == IW'(SLICES - 1));

  cla16 u_cla (
    .a   (a_sl),
    .b   (b_sl),
    .cin (carry_q),
    .s   (s),
    .p   (p),
    .g   (g)
  );

  assign slice_co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) |
                    (p[3] & p[2] & p[1] & g[0]) |
                    (p[3] & p[2] & p[1] & p[0] & carry_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b_in;
            carry_q <= cin_in;
            idx     <= '0;
          end
        end
        RUN: begin
          sum[16*idx +: 16] <= s;
          carry_q           <= slice_co;
          // Index wraps to 0 on the last slice so it never leaves 0..SLICES-1.
          if (last) begin
            cout <= slice_co;
            idx  <= '0;
          end else begin
            idx  <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_multiword_adder_seq.sv
// Randomized bench for multiword_adder_seq (SLICES=4) against a plain-arithmetic model.
module tb_multiword_adder_seq;
  localparam int SLICES = 4;
  localparam int W = 16 * SLICES;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int total = 0;
  int bad = 0;
  logic [W-1:0] prev_sum;
  logic         prev_cout;

  multiword_adder_seq #(.SLICES(SLICES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SUBTRACT_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] xa, input logic [W-1:0] xb,
                                       input logic xc, input logic xs);
    logic [W:0] r;
    if (xs) r = {1'b0, xa} + {1'b0, ~xb} + (W+1)'(1);
    else    r = {1'b0, xa} + {1'b0, xb} + (W+1)'(xc);
    return r;
  endfunction

  function automatic logic [W-1:0] rnd64();
    logic [W-1:0] r;
    r = {$urandom, $urandom};
    case ($urandom_range(0, 3))
      0: r = {W{1'b1}};
      1: r = r & 64'h0000_0000_0000_FFFF;
      default: ;
    endcase
    return r;
  endfunction

  // Called right after a negedge; returns on a negedge with the block idle.
  task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input logic xc, input logic xs, input bit poke);
    logic [W:0] exp;
    int busy_cnt;
    int done_cnt;
    int done_pos;
    exp = model(xa, xb, xc, xs);
    a = xa; b = xb; cin = xc; sub = xs; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = rnd64(); b = rnd64(); cin = 1'($urandom); sub = 1'b0;
    busy_cnt = 0; done_cnt = 0; done_pos = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk("hold_sum", sum, prev_sum);
        chk("hold_cout", W'(cout), W'(prev_cout));
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_pos < 0) done_pos = i;
      end
      if (poke && (i == 1 || i == 4)) begin
        a = rnd64(); b = rnd64(); start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    chk("busy_cycles", W'(busy_cnt), W'(SLICES));
    chk("done_cycles", W'(done_cnt), 64'd1);
    chk("done_pos", W'(done_pos), W'(SLICES));
    chk("sum", sum, exp[W-1:0]);
    chk("cout", W'(cout), W'(exp[W]));
    prev_sum = exp[W-1:0];
    prev_cout = exp[W];
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    prev_sum = '0; prev_cout = 1'b0;
    #12;
    chk("rst_busy", W'(busy), 64'd0);
    chk("rst_done", W'(done), 64'd0);
    chk("rst_sum", sum, 64'd0);
    chk("rst_cout", W'(cout), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(64'h19E, 64'h40C, 1'b0, 1'b0, 1'b0);
    run_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 1'b0);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 1'b0);
    run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b0);
    run_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0, 1'b1);

    // Reset in the second RUN cycle abandons the operation.
    a = 64'hFFFF_0000_FFFF_0000; b = 64'h1111_2222_3333_4444; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", W'(busy), 64'd0);
    chk("midrst_done", W'(done), 64'd0);
    chk("midrst_sum", sum, 64'd0);
    chk("midrst_cout", W'(cout), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int dcnt;
      dcnt = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (done || busy) dcnt++;
      end
      chk("no_done_after_rst", W'(dcnt), 64'd0);
    end
    prev_sum = '0; prev_cout = 1'b0;
    run_op(64'h19E, 64'h40C, 1'b0, 1'b0, 1'b0);

`ifdef SUBTRACT_EN
    run_op(64'd5, 64'd7, 1'b0, 1'b1, 1'b0);
    run_op(64'd7, 64'd5, 1'b1, 1'b1, 1'b0);
`endif

    for (int n = 0; n < 24; n++) begin
      logic xs;
`ifdef SUBTRACT_EN
      xs = 1'($urandom);
`else
      xs = 1'b0;
`endif
      run_op(rnd64(), rnd64(), 1'($urandom), xs, bit'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
